// File: rtl/lcd_pkg.sv
// Shared types for the ILI9341-style SPI byte writer: FSM states, FIFO entry layout,
// and the SCK half-period helper.
package lcd_pkg;

  localparam int unsigned DATA_W         = 8;
  localparam int unsigned TICKS_PER_BYTE = 2 * DATA_W;
  localparam int unsigned TICK_CNT_W     = $clog2(TICKS_PER_BYTE);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } lcd_state_e;

  typedef struct packed {
    logic              dc;
    logic [DATA_W-1:0] data;
  } lcd_entry_t;

  // System clock cycles per SCK half-period; 0 means the requested rate is unreachable.
  function automatic int unsigned sck_half_cycles(input int unsigned f_in,
                                                  input int unsigned f_sck);
    return (f_sck == 0) ? 0 : f_in / f_sck / 2;
  endfunction

endpackage

// File: rtl/lcd_byte_fifo.sv
// Synchronous first-word-fall-through FIFO of {dc,data} entries.
// Pushes while full and pops while empty are ignored.
module lcd_byte_fifo
  import lcd_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       rst,
  input  logic       i_push,
  input  lcd_entry_t i_entry,
  input  logic       i_pop,
  output lcd_entry_t o_entry,
  output logic       o_full,
  output logic       o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("lcd_byte_fifo: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  lcd_entry_t        mem_q [DEPTH];
  lcd_entry_t        mem_d [DEPTH];
  logic     [PW-1:0] wr_q, wr_d;
  logic     [PW-1:0] rd_q, rd_d;
  logic              push_ok;
  logic              pop_ok;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty = (wr_q == rd_q);
  assign o_full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign o_entry = mem_q[rd_q[AW-1:0]];

  always_comb begin
    push_ok = i_push && !o_full;
    pop_ok  = i_pop && !o_empty;
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    if (push_ok) begin
      mem_d[wr_q[AW-1:0]] = i_entry;
      wr_d                = wr_q + PW'(1);
    end
    if (pop_ok) begin
      rd_d = rd_q + PW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/lcd_spi_writer.sv
// Buffered SPI mode-0 writer for ILI9341-style panels: streams {dc,byte} entries
// MSB first, holding CS low across back-to-back bytes.
module lcd_spi_writer
  import lcd_pkg::*;
#(
  parameter int unsigned FREQUENCY_IN  = 100_000_000,
  parameter int unsigned FREQUENCY_SCK = 10_000_000,
  parameter int unsigned FIFO_DEPTH    = 4
) (
  input  logic              i_clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_dc,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic              o_sck,
  output logic              o_mosi,
  output logic              o_dc,
  output logic              o_cs_n,
  output logic              o_busy
);

  localparam int unsigned HALF  = sck_half_cycles(FREQUENCY_IN, FREQUENCY_SCK);
  localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;

  generate
    if (HALF < 1) begin : g_bad_half
      $error("lcd_spi_writer: FREQUENCY_SCK too high for FREQUENCY_IN (half period < 1 cycle)");
    end
  endgenerate

  lcd_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [TICK_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]       sr_q, sr_d;
  logic                    sck_q, sck_d;
  logic                    mosi_q, mosi_d;
  logic                    dc_q, dc_d;
  logic                    cs_n_q, cs_n_d;
  logic                    tick;
  logic                    fifo_pop;
  logic                    fifo_full;
  logic                    fifo_empty;
  lcd_entry_t              fifo_head;
  lcd_entry_t              push_entry;

  assign push_entry = '{dc: i_dc, data: i_data};

  lcd_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .rst     (rst),
    .i_push  (i_valid),
    .i_entry (push_entry),
    .i_pop   (fifo_pop),
    .o_entry (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  assign tick    = (state_q != ST_IDLE) && (cnt_q == CNT_W'(HALF - 1));
  assign o_ready = !fifo_full;
  assign o_busy  = (state_q != ST_IDLE) || !fifo_empty;
  assign o_sck   = sck_q;
  assign o_mosi  = mosi_q;
  assign o_dc    = dc_q;
  assign o_cs_n  = cs_n_q;

  // Next-state and output logic; every SCK edge lands on a half-period tick.
  always_comb begin
    state_d   = state_q;
    cnt_d     = tick ? '0 : cnt_q + CNT_W'(1);
    bit_cnt_d = bit_cnt_q;
    sr_d      = sr_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    dc_d      = dc_q;
    cs_n_d    = cs_n_q;
    fifo_pop  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        sck_d  = 1'b0;
        cs_n_d = 1'b1;
        if (!fifo_empty) begin
          fifo_pop  = 1'b1;
          state_d   = ST_SETUP;
          sr_d      = fifo_head.data;
          mosi_d    = fifo_head.data[DATA_W-1];
          dc_d      = fifo_head.dc;
          cs_n_d    = 1'b0;
          bit_cnt_d = '0;
        end
      end

      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (tick) begin
          bit_cnt_d = bit_cnt_q + TICK_CNT_W'(1);
          sck_d     = !sck_q;
          if (sck_q) begin
            if (bit_cnt_q == TICK_CNT_W'(TICKS_PER_BYTE - 1)) begin
              // Last falling edge: chain the next byte without releasing CS.
              if (!fifo_empty) begin
                fifo_pop = 1'b1;
                sr_d     = fifo_head.data;
                mosi_d   = fifo_head.data[DATA_W-1];
                dc_d     = fifo_head.dc;
              end else begin
                state_d = ST_HOLD;
              end
            end else begin
              sr_d   = sr_q << 1;
              mosi_d = sr_q[DATA_W-2];
            end
          end
        end
      end

      ST_HOLD: begin
        sck_d = 1'b0;
        if (tick) begin
          state_d = ST_IDLE;
          cs_n_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      sr_q      <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      dc_q      <= 1'b0;
      cs_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      dc_q      <= dc_d;
      cs_n_q    <= cs_n_d;
    end
  end

endmodule

// File: tb/tb_lcd_spi_writer.sv
// Scoreboard bench for lcd_spi_writer at 100 MHz / 10 MHz (HALF = 5): accepted
// pushes are queued and matched against bytes reassembled from SCK/MOSI.
module tb_lcd_spi_writer;

  localparam int unsigned HALF = 5;

  logic       i_clk;
  logic       rst;
  logic       i_valid;
  logic       i_dc;
  logic [7:0] i_data;
  logic       o_ready;
  logic       o_sck;
  logic       o_mosi;
  logic       o_dc;
  logic       o_cs_n;
  logic       o_busy;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [8:0] sb[$];

  int         cyc = 0;
  logic       sck_prev = 1'b0;
  logic       cs_prev = 1'b1;
  logic       mosi_prev = 1'b0;
  logic       dc_prev = 1'b0;
  int         nbits = 0;
  logic [7:0] bits = '0;
  logic       dc_byte = 1'b0;
  logic [8:0] exp_e;
  int         cs_start = 0;
  int         cs_low_len = 0;
  int         rise_cnt = 0;
  int         pulses = 0;
  int         windows = 0;
  int         byte_start = 0;
  bit         first_byte = 1'b1;

  lcd_spi_writer #(
    .FREQUENCY_IN  (100_000_000),
    .FREQUENCY_SCK (10_000_000),
    .FIFO_DEPTH    (4)
  ) dut (
    .i_clk   (i_clk),
    .rst     (rst),
    .i_valid (i_valid),
    .i_dc    (i_dc),
    .i_data  (i_data),
    .o_ready (o_ready),
    .o_sck   (o_sck),
    .o_mosi  (o_mosi),
    .o_dc    (o_dc),
    .o_cs_n  (o_cs_n),
    .o_busy  (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // SPI-side monitor: rebuild bytes on SCK rising edges and measure CS windows.
  always @(negedge i_clk) begin
    cyc++;
    if (!rst) begin
      nbits     = 0;
      rise_cnt  = 0;
      sck_prev  = 1'b0;
      cs_prev   = 1'b1;
      mosi_prev = 1'b0;
      dc_prev   = 1'b0;
    end else begin
      if (cs_prev && !o_cs_n) begin
        cs_start   = cyc;
        rise_cnt   = 0;
        first_byte = 1'b1;
      end
      if (!cs_prev && o_cs_n) begin
        cs_low_len = cyc - cs_start;
        pulses     = rise_cnt;
        windows++;
        check("partial_byte_at_cs_rise", 32'(nbits), 32'd0);
      end
      if (o_sck && sck_prev) begin
        check("mosi_stable_sck_high", 32'(o_mosi), 32'(mosi_prev));
        check("dc_stable_sck_high", 32'(o_dc), 32'(dc_prev));
      end
      if (o_sck && !sck_prev) begin
        check("cs_low_at_sck_rise", 32'(o_cs_n), 32'd0);
        rise_cnt++;
        if (nbits == 0) begin
          if (!first_byte) check("byte_spacing", 32'(cyc - byte_start), 32'(16 * HALF));
          first_byte = 1'b0;
          byte_start = cyc;
          dc_byte    = o_dc;
        end
        bits = {bits[6:0], o_mosi};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          if (sb.size() == 0) begin
            check("sb_underflow", 32'd1, 32'd0);
          end else begin
            exp_e = sb.pop_front();
            check("byte_data", 32'(bits), 32'(exp_e[7:0]));
            check("byte_dc", 32'(dc_byte), 32'(exp_e[8]));
          end
        end
      end
      sck_prev  = o_sck;
      cs_prev   = o_cs_n;
      mosi_prev = o_mosi;
      dc_prev   = o_dc;
    end
  end

  // Leaves i_valid high so consecutive calls push with no gap.
  task automatic push(input logic dc, input logic [7:0] d);
    int w = 0;
    i_valid = 1'b1;
    i_dc    = dc;
    i_data  = d;
    while (!o_ready && w < 500) begin
      @(posedge i_clk);
      #1;
      w++;
    end
    if (!o_ready) check("push_ready_timeout", 32'd0, 32'd1);
    @(posedge i_clk);
    #1;
    sb.push_back({dc, d});
  endtask

  task automatic wait_idle(input int budget);
    int w = 0;
    do begin
      @(posedge i_clk);
      #1;
      w++;
    end while ((o_busy || !o_cs_n) && w < budget);
    if (o_busy || !o_cs_n) check("idle_timeout", 32'd0, 32'd1);
    repeat (3) @(posedge i_clk);
    #1;
  endtask

  task automatic check_window(input string tag, input int w0, input int len, input int npulse);
    check({tag, "_windows"}, 32'(windows), 32'(w0 + 1));
    check({tag, "_cs_low_len"}, 32'(cs_low_len), 32'(len));
    check({tag, "_sck_pulses"}, 32'(pulses), 32'(npulse));
    check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int  w0;
    int  r;
    int  t;
    logic prev;
    logic bad;

    rst     = 1'b0;
    i_valid = 1'b0;
    i_dc    = 1'b0;
    i_data  = '0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_sck", 32'(o_sck), 32'd0);
    check("rst_mosi", 32'(o_mosi), 32'd0);
    check("rst_dc", 32'(o_dc), 32'd0);
    check("rst_cs_n", 32'(o_cs_n), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd1);
    rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;

    // Single command byte 0x2A.
    w0 = windows;
    push(1'b0, 8'h2A);
    i_valid = 1'b0;
    check("single_cs_before_pop", 32'(o_cs_n), 32'd1);
    check("single_busy_queued", 32'(o_busy), 32'd1);
    @(posedge i_clk);
    #1;
    check("single_cs_after_pop", 32'(o_cs_n), 32'd0);
    check("single_sck_setup", 32'(o_sck), 32'd0);
    wait_idle(500);
    check_window("single", w0, 90, 8);

    // Command 0x2C followed by two data bytes in one burst.
    w0 = windows;
    push(1'b0, 8'h2C);
    push(1'b1, 8'h12);
    push(1'b1, 8'h34);
    i_valid = 1'b0;
    wait_idle(1000);
    check_window("burst3", w0, 250, 24);

    // Five gapless pushes overrun a depth-4 FIFO briefly.
    w0 = windows;
    push(1'b0, 8'hA1);
    push(1'b1, 8'h5B);
    push(1'b0, 8'h00);
    push(1'b1, 8'hFF);
    push(1'b1, 8'h3C);
    i_valid = 1'b0;
    check("fifo_full_ready_low", 32'(o_ready), 32'd0);
    wait_idle(2000);
    check_window("burst5", w0, 410, 40);

    // Reset at the 4th SCK rising edge of a burst with 3 entries queued.
    w0 = windows;
    push(1'b0, 8'h11);
    push(1'b1, 8'h22);
    push(1'b1, 8'h33);
    push(1'b1, 8'h44);
    i_valid = 1'b0;
    r    = 0;
    t    = 0;
    prev = o_sck;
    while (r < 4 && t < 300) begin
      @(posedge i_clk);
      #1;
      if (o_sck && !prev) r++;
      prev = o_sck;
      t++;
    end
    check("abort_reached_4th_rise", 32'(r), 32'd4);
    rst = 1'b0;
    #1;
    sb.delete();
    check("abort_sck", 32'(o_sck), 32'd0);
    check("abort_mosi", 32'(o_mosi), 32'd0);
    check("abort_dc", 32'(o_dc), 32'd0);
    check("abort_cs_n", 32'(o_cs_n), 32'd1);
    check("abort_busy", 32'(o_busy), 32'd0);
    check("abort_ready", 32'(o_ready), 32'd1);
    repeat (3) @(posedge i_clk);
    #1;
    rst = 1'b1;
    bad = 1'b0;
    repeat (60) begin
      @(posedge i_clk);
      #1;
      if (o_sck || !o_cs_n || o_busy) bad = 1'b1;
    end
    check("abort_no_activity_after", 32'(bad), 32'd0);
    check("abort_no_window", 32'(windows), 32'(w0));

    // Long idle, then a single 0xFF with the same timing as the first byte.
    bad = 1'b0;
    repeat (200) begin
      @(posedge i_clk);
      #1;
      if (o_sck || !o_cs_n) bad = 1'b1;
    end
    check("idle_quiet", 32'(bad), 32'd0);
    w0 = windows;
    push(1'b0, 8'hFF);
    i_valid = 1'b0;
    check("late_cs_before_pop", 32'(o_cs_n), 32'd1);
    @(posedge i_clk);
    #1;
    check("late_cs_after_pop", 32'(o_cs_n), 32'd0);
    wait_idle(500);
    check_window("late", w0, 90, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
